// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared constants for the RV32I pipeline: bubble encoding,
//                default reset PC, instruction-field slice positions, IF/ID
//                register layout and a word-alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // addi x0, x0, 0 : a legal instruction with no architectural effect
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction-field slice positions used by the decode-stage controller
    localparam int OP_LSB       = 0;
    localparam int OP_MSB       = 6;
    localparam int FUNCT3_LSB   = 12;
    localparam int FUNCT3_MSB   = 14;
    localparam int FUNCT7B5_BIT = 30;

    // IF/ID register layout: {Instr, PC, PCPlus4, Valid}
    localparam int IFID_W = 32 + 32 + 32 + 1;

    // Bubble contents loaded into IF/ID on reset or flush
    localparam logic [IFID_W-1:0] IFID_BUBBLE = {NOP_INSTR, 32'h0, 32'h0, 1'b0};

    // Clears the two byte-offset bits so a fetch address is always word aligned
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_stage_flopenrc.sv
`default_nettype none
// ============================================================================
//  Module      : flopenrc
//  Description : Parameterised-width register with synchronous reset,
//                synchronous clear and load enable. Reset and clear both load
//                RESET_VAL; priority is rst > i_clr > i_en.
//  Ports       : clk   - clock
//                rst   - synchronous active-high reset
//                i_en  - load enable
//                i_clr - synchronous clear (independent of i_en)
//                i_d   - next value
//                o_q   - registered value
//  Revision    : 1.0 - initial release
// ============================================================================
module flopenrc #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (i_clr) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : flopenrc
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : RV32I instruction-fetch stage plus IF/ID pipeline register.
//                Holds the PC, selects sequential or redirected next PC and
//                registers the fetched instruction into decode, obeying
//                stall/flush requests from the hazard unit.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                StallF, StallD      - hold PC / hold IF/ID
//                FlushD              - squash IF/ID to a NOP bubble
//                PCSrcE, PCTargetE   - redirect request and target from execute
//                PCF, PCPlus4F       - fetch address and its sequential successor
//                InstrF              - instruction word read at PCF
//                InstrD, PCD,
//                PCPlus4D, ValidD    - decode-stage instruction and its PCs/valid
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] PCF,
    input  logic [31:0] InstrF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    logic [31:0]       r_pcf;
    logic [31:0]       w_pcplus4f;
    logic [31:0]       w_pc_next;
    logic              w_pc_en;
    logic [IFID_W-1:0] w_ifid_d;
    logic [IFID_W-1:0] r_ifid;

    // Sequential successor; wraps modulo 2^32 with no flag
    assign w_pcplus4f = r_pcf + 32'd4;

    // A redirect must load even while the PC is stalled, so it both selects
    // the target and forces the enable.
    assign w_pc_next = PCSrcE ? align_word(PCTargetE) : w_pcplus4f;
    assign w_pc_en   = PCSrcE | ~StallF;

    flopenrc #(
        .WIDTH     (32),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst   (reset),
        .i_en  (w_pc_en),
        .i_clr (1'b0),
        .i_d   (w_pc_next),
        .o_q   (r_pcf)
    );

    // Clear takes precedence over enable inside flopenrc, so FlushD wins
    // over StallD when both are asserted.
    assign w_ifid_d = {InstrF, r_pcf, w_pcplus4f, 1'b1};

    flopenrc #(
        .WIDTH     (IFID_W),
        .RESET_VAL (IFID_BUBBLE)
    ) u_ifid_reg (
        .clk   (clk),
        .rst   (reset),
        .i_en  (~StallD),
        .i_clr (FlushD),
        .i_d   (w_ifid_d),
        .o_q   (r_ifid)
    );

    assign PCF      = r_pcf;
    assign PCPlus4F = w_pcplus4f;
    assign InstrD   = r_ifid[96:65];
    assign PCD      = r_ifid[64:33];
    assign PCPlus4D = r_ifid[32:1];
    assign ValidD   = r_ifid[0];

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage. A second
//                instance with RESET_PC = 32'hFFFF_FFFC exercises PC wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic [31:0] PCF2, PCPlus4F2, InstrD2, PCD2, PCPlus4D2;
    logic        ValidD2;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .PCF(PCF), .InstrF(InstrF), .PCPlus4F(PCPlus4F), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .PCF(PCF2), .InstrF(InstrF), .PCPlus4F(PCPlus4F2), .InstrD(InstrD2),
        .PCD(PCD2), .PCPlus4D(PCPlus4D2), .ValidD(ValidD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench instruction memory: address-dependent words, 0x00500093 at PC 0
    function automatic logic [31:0] imem(input logic [31:0] pc);
        return 32'h0050_0093 ^ (pc << 16);
    endfunction

    always_comb InstrF = imem(PCF);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_d(input string tag, input logic [31:0] instr,
                           input logic [31:0] pc, input logic [31:0] pc4,
                           input logic valid);
        check({tag, ".InstrD"},   InstrD,   instr);
        check({tag, ".PCD"},      PCD,      pc);
        check({tag, ".PCPlus4D"}, PCPlus4D, pc4);
        check({tag, ".ValidD"},   {31'b0, ValidD}, {31'b0, valid});
    endtask

    initial begin
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = 32'h0;

        // Reset held for two cycles
        step();
        step();
        check("rst.PCF",      PCF,      32'h0);
        check("rst.PCPlus4F", PCPlus4F, 32'h4);
        check("rst.InstrF",   InstrF,   32'h0050_0093);
        check_d("rst", c_NOP, 32'h0, 32'h0, 1'b0);
        check("rst.wrap.PCF",      PCF2,      32'hFFFF_FFFC);
        check("rst.wrap.PCPlus4F", PCPlus4F2, 32'h0);

        // First fetch after release
        reset = 1'b0;
        step();
        check("run1.PCF", PCF, 32'h4);
        check_d("run1", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
        check("wrap.PCF", PCF2, 32'h0);
        step();
        check("run2.PCF", PCF, 32'h8);
        check_d("run2", imem(32'h4), 32'h4, 32'h8, 1'b1);

        // Stall both F and D for two cycles at PCF = 8
        StallF = 1'b1; StallD = 1'b1;
        step();
        check("stall1.PCF", PCF, 32'h8);
        check_d("stall1", imem(32'h4), 32'h4, 32'h8, 1'b1);
        step();
        check("stall2.PCF", PCF, 32'h8);
        check_d("stall2", imem(32'h4), 32'h4, 32'h8, 1'b1);
        StallF = 1'b0; StallD = 1'b0;
        step();
        check("unstall.PCF", PCF, 32'hC);
        check_d("unstall", imem(32'h8), 32'h8, 32'hC, 1'b1);
        step();
        check("run3.PCF", PCF, 32'h10);

        // Redirect with flush at PCF = 16, misaligned target
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0103; FlushD = 1'b1;
        step();
        check("redir.PCF",      PCF,      32'h100);
        check("redir.PCPlus4F", PCPlus4F, 32'h104);
        check_d("redir", c_NOP, 32'h0, 32'h0, 1'b0);
        PCSrcE = 1'b0; FlushD = 1'b0;
        step();
        check("post_redir.PCF", PCF, 32'h104);
        check_d("post_redir", imem(32'h100), 32'h100, 32'h104, 1'b1);

        // Redirect while StallF is asserted: redirect still taken
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0203; FlushD = 1'b1; StallF = 1'b1;
        step();
        check("redir_stall.PCF", PCF, 32'h200);
        check_d("redir_stall", c_NOP, 32'h0, 32'h0, 1'b0);
        PCSrcE = 1'b0; FlushD = 1'b0; StallF = 1'b0;
        step();
        check("post_rs.PCF", PCF, 32'h204);
        check_d("post_rs", imem(32'h200), 32'h200, 32'h204, 1'b1);

        // FlushD together with StallD: bubble wins
        StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1;
        step();
        check("flush_stall.PCF", PCF, 32'h204);
        check_d("flush_stall", c_NOP, 32'h0, 32'h0, 1'b0);
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        step();
        check("post_fs.PCF", PCF, 32'h208);
        check_d("post_fs", imem(32'h204), 32'h204, 32'h208, 1'b1);

        // StallD alone holds IF/ID while PC advances
        StallD = 1'b1;
        step();
        check("stalld.PCF", PCF, 32'h20C);
        check_d("stalld", imem(32'h204), 32'h204, 32'h208, 1'b1);
        StallD = 1'b0;

        // Reset mid-stream with stall and redirect active
        reset = 1'b1; StallF = 1'b1; StallD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h300;
        step();
        check("rst2.PCF", PCF, 32'h0);
        check_d("rst2", c_NOP, 32'h0, 32'h0, 1'b0);
        check("rst2.wrap.PCF", PCF2, 32'hFFFF_FFFC);
        reset = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcE = 1'b0;
        step();
        check("rst2_rel.PCF", PCF, 32'h4);
        check_d("rst2_rel", 32'h0050_0093, 32'h0, 32'h4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
